accel_sample_assembler: RTL and testbench

Upstream feeder of the averaging stage. Periodically requests an 8-byte burst read (XDATA_L..TEMP_H) from the SPI master, assembles the little-endian bytes into 12-bit signed X/Y/Z samples and a scaled 19-bit signed temperature, then pulses a one-cycle data-ready strobe. Its outputs connect directly to the averaging stage's data and data-ready inputs. It owns the sample-rate timer and detects SPI timeouts and sample overruns.

---
 rtl/accel_sample_assembler.sv | 184 ++++++++++++++++++
 tb/tb_accel_sample_assembler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_sample_assembler.sv
// accel_sample_assembler
// Periodically requests an 8-byte burst (X_L..T_H) from the SPI master and
// assembles it into signed 12-bit X/Y/Z samples plus a scaled 19-bit signed
// temperature. It then strobes data-ready for the averaging stage. It owns
// the sample-rate timer and flags byte-gap timeouts and sample overruns.
//
// Handshake: i_SPI_ByteValid is a one-cycle qualifier for i_SPI_Byte. It is
// sampled only while collecting and is ignored in every other state.
// o_SPI_Start, o_AVG_dataReady, o_ACCEL_Timeout and o_ACCEL_Overrun are
// registered strobes, each high for exactly one cycle. o_ACCEL_X/Y/Z/T change
// only in the cycle o_AVG_dataReady is high, and they hold until the next
// completed frame.
module accel_sample_assembler #(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int TIMEOUT       = 4096,
  parameter int T_OFFSET      = 350,
  parameter int T_SCALE       = 65
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_SPI_Byte,
  input  logic        i_SPI_ByteValid,
  input  logic        i_SPI_Busy,
  output logic        o_SPI_Start,
  output logic [11:0] o_ACCEL_X,
  output logic [11:0] o_ACCEL_Y,
  output logic [11:0] o_ACCEL_Z,
  output logic [18:0] o_ACCEL_T,
  output logic        o_AVG_dataReady,
  output logic        o_ACCEL_Timeout,
  output logic        o_ACCEL_Overrun,
  output logic [1:0]  dbg_state
);

  localparam int TICK_W = $clog2(SAMPLE_PERIOD);
  localparam int GAP_W  = $clog2(TIMEOUT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_COLLECT = 2'd2,
    S_CONVERT = 2'd3
  } state_t;

  state_t            state;
  logic              pending;
  logic [2:0]        byte_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  // Shadow bytes per value: full low byte, low nibble of the high byte.
  // H[7:4] carries no information, so it is never stored.
  logic [7:0] shadow_l [4];
  logic [3:0] shadow_h [4];

  logic [11:0] raw_x;
  logic [11:0] raw_y;
  logic [11:0] raw_z;
  logic [11:0] raw_t;

  // Temperature path in two's complement. The subtraction and multiplication
  // are kept at 19 bits on purpose: the low 19 bits of the product are the
  // truncated signed result whatever the operand signedness.
  logic [18:0] t_ext;
  logic [18:0] t_diff;
  logic [18:0] t_scaled;

  assign dbg_state = state;
  assign tick      = (tick_cnt == TICK_LAST);

  assign raw_x = {shadow_h[0], shadow_l[0]};
  assign raw_y = {shadow_h[1], shadow_l[1]};
  assign raw_z = {shadow_h[2], shadow_l[2]};
  assign raw_t = {shadow_h[3], shadow_l[3]};

  assign t_ext    = {{7{raw_t[11]}}, raw_t};
  assign t_diff   = t_ext - 19'(T_OFFSET);
  assign t_scaled = t_diff * 19'(T_SCALE);

  // Free-running sample-rate timer: counts 0..SAMPLE_PERIOD-1 and wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Frame FSM: request, byte collection with gap timeout, conversion, and
  // the registered strobes and data outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      pending         <= 1'b0;
      byte_idx        <= '0;
      gap_cnt         <= '0;
      o_SPI_Start     <= 1'b0;
      o_AVG_dataReady <= 1'b0;
      o_ACCEL_Timeout <= 1'b0;
      o_ACCEL_Overrun <= 1'b0;
      o_ACCEL_X       <= '0;
      o_ACCEL_Y       <= '0;
      o_ACCEL_Z       <= '0;
      o_ACCEL_T       <= '0;
      for (int i = 0; i < 4; i++) begin
        shadow_l[i] <= '0;
        shadow_h[i] <= '0;
      end
    end else begin
      o_SPI_Start     <= 1'b0;
      o_AVG_dataReady <= 1'b0;
      o_ACCEL_Timeout <= 1'b0;

      // A tick that cannot be served right away is an overrun. Only one
      // request is remembered, so pending simply stays set.
      o_ACCEL_Overrun <= tick && ((state != S_IDLE) || pending);

      if (tick) begin
        pending <= 1'b1;
      end else if ((state == S_IDLE) && pending && !i_SPI_Busy) begin
        pending <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (pending && !i_SPI_Busy) begin
            state       <= S_REQ;
            o_SPI_Start <= 1'b1;
          end
        end

        S_REQ: begin
          state    <= S_COLLECT;
          byte_idx <= '0;
          gap_cnt  <= '0;
        end

        S_COLLECT: begin
          if (i_SPI_ByteValid) begin
            if (byte_idx[0]) begin
              shadow_h[byte_idx[2:1]] <= i_SPI_Byte[3:0];
            end else begin
              shadow_l[byte_idx[2:1]] <= i_SPI_Byte;
            end
            byte_idx <= byte_idx + 3'd1;
            gap_cnt  <= '0;
            if (byte_idx == 3'd7) begin
              state <= S_CONVERT;
            end
          end else if (gap_cnt == GAP_LAST) begin
            // Partial shadow contents are abandoned; the next frame
            // overwrites them from index 0 before they are ever converted.
            o_ACCEL_Timeout <= 1'b1;
            state           <= S_IDLE;
            byte_idx        <= '0;
            gap_cnt         <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_CONVERT: begin
          o_ACCEL_X       <= raw_x;
          o_ACCEL_Y       <= raw_y;
          o_ACCEL_Z       <= raw_z;
          o_ACCEL_T       <= t_scaled;
          o_AVG_dataReady <= 1'b1;
          state           <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_sample_assembler.sv
// Bench for accel_sample_assembler: a fixed table of frames with known
// results, randomized frames scored against a behavioural model, and
// hand-written sequences for busy, timeout, overrun and mid-frame reset.
module tb_accel_sample_assembler;

  localparam int P     = 64;
  localparam int TO    = 16;
  localparam int T_OFF = 350;
  localparam int T_SC  = 65;
  localparam int W     = 55;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  i_SPI_Byte      = 8'h00;
  logic        i_SPI_ByteValid = 1'b0;
  logic        i_SPI_Busy      = 1'b0;
  logic        o_SPI_Start;
  logic [11:0] o_ACCEL_X;
  logic [11:0] o_ACCEL_Y;
  logic [11:0] o_ACCEL_Z;
  logic [18:0] o_ACCEL_T;
  logic        o_AVG_dataReady;
  logic        o_ACCEL_Timeout;
  logic        o_ACCEL_Overrun;
  logic [1:0]  dbg_state;

  accel_sample_assembler #(
    .SAMPLE_PERIOD(P),
    .TIMEOUT(TO),
    .T_OFFSET(T_OFF),
    .T_SCALE(T_SC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_SPI_Byte(i_SPI_Byte),
    .i_SPI_ByteValid(i_SPI_ByteValid),
    .i_SPI_Busy(i_SPI_Busy),
    .o_SPI_Start(o_SPI_Start),
    .o_ACCEL_X(o_ACCEL_X),
    .o_ACCEL_Y(o_ACCEL_Y),
    .o_ACCEL_Z(o_ACCEL_Z),
    .o_ACCEL_T(o_ACCEL_T),
    .o_AVG_dataReady(o_AVG_dataReady),
    .o_ACCEL_Timeout(o_ACCEL_Timeout),
    .o_ACCEL_Overrun(o_ACCEL_Overrun),
    .dbg_state(dbg_state)
  );

  // Cycle number since reset release: cycle k follows the k-th rising edge
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- strobe monitor (samples 3 time units after the edge) ----------------
  int   dr_cnt = 0, to_cnt = 0, ov_cnt = 0, to_cyc = -1, ov_cyc = -1;
  int   dbl_cnt = 0, overlap_cnt = 0;
  logic prev_dr = 0, prev_to = 0, prev_ov = 0, prev_st = 0;
  always @(posedge clk) begin
    #3;
    if (reset) begin
      prev_dr = 0; prev_to = 0; prev_ov = 0; prev_st = 0;
    end else begin
      if (o_AVG_dataReady) dr_cnt++;
      if (o_ACCEL_Timeout) begin to_cnt++; to_cyc = cyc; end
      if (o_ACCEL_Overrun) begin ov_cnt++; ov_cyc = cyc; end
      if ((o_AVG_dataReady && prev_dr) || (o_ACCEL_Timeout && prev_to) ||
          (o_ACCEL_Overrun && prev_ov) || (o_SPI_Start && prev_st)) dbl_cnt++;
      if (o_SPI_Start && o_AVG_dataReady) overlap_cnt++;
      prev_dr = o_AVG_dataReady; prev_to = o_ACCEL_Timeout;
      prev_ov = o_ACCEL_Overrun; prev_st = o_SPI_Start;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_frame = '0;
  int n_total = 0;
  int n_pass  = 0;
  int last_byte_cyc = 0;
  int last_start = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] dut_word();
    return {o_ACCEL_X, o_ACCEL_Y, o_ACCEL_Z, o_ACCEL_T};
  endfunction

  // Behavioural model: little-endian byte pairs, 12-bit two's complement,
  // temperature scaled with plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [63:0] f);
    int v[4];
    int t;
    for (int k = 0; k < 4; k++) begin
      v[k] = int'(f[16*k+8 +: 4]) * 256 + int'(f[16*k +: 8]);
      if (v[k] >= 2048) v[k] -= 4096;
    end
    t = (v[3] - T_OFF) * T_SC;
    return {12'(v[0]), 12'(v[1]), 12'(v[2]), 19'(t)};
  endfunction

  // First start at P+1, then every P cycles when nothing delays it
  function automatic int next_slot(input int c);
    if (c < P + 1) return P + 1;
    return (P + 1) + P * ((c - P - 1) / P + 1);
  endfunction

  // ---------------- driver tasks (all entered and left on a falling edge) ----------------
  task automatic wait_start(input int exp_cyc, input string name);
    for (int k = 0; k < 300 && !o_SPI_Start; k++) @(negedge clk);
    if (o_SPI_Start) check(name, cyc, exp_cyc);
    else             check({name, "_seen"}, 0, 1);
    last_start = cyc;
    check({name, "_hold"}, dut_word(), last_frame);
  endtask

  task automatic send_frame(input logic [63:0] f, input int n, input int first_dly,
                            input int glo, input int ghi);
    repeat (first_dly) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      i_SPI_Byte      = f[8*i +: 8];
      i_SPI_ByteValid = 1'b1;
      last_byte_cyc   = cyc;
      @(negedge clk);
      i_SPI_ByteValid = 1'b0;
      i_SPI_Byte      = 8'($urandom);
      if (i < n - 1) repeat ($urandom_range(ghi, glo)) @(negedge clk);
    end
  endtask

  task automatic expect_frame(input string name);
    logic [W-1:0] e;
    int got;
    for (int k = 0; k < 6 && !o_AVG_dataReady; k++) @(negedge clk);
    got = o_AVG_dataReady ? cyc : -1;
    check({name, "_drdy_cycle"}, got, last_byte_cyc + 2);
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_x"}, o_ACCEL_X, e[54:43]);
      check({name, "_y"}, o_ACCEL_Y, e[42:31]);
      check({name, "_z"}, o_ACCEL_Z, e[30:19]);
      check({name, "_t"}, o_ACCEL_T, e[18:0]);
      last_frame = e;
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_data"}, dut_word(), '0);
    check({name, "_strobes"}, {o_SPI_Start, o_AVG_dataReady, o_ACCEL_Timeout, o_ACCEL_Overrun}, 4'b0);
  endtask

  task automatic random_frame(input string name);
    logic [63:0] f;
    f = {32'($urandom), 32'($urandom)};
    exp_q.push_back(model(f));
    send_frame(f, 8, $urandom_range(3, 1), 0, 3);
    expect_frame(name);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [63:0] frame;
    int x;
    int y;
    int z;
    int t;
  } vec_t;
  vec_t tbl[5];

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, ov0, to0, dr0;
    logic [63:0] f;

    tbl[0] = '{64'h015E_07FF_F800_0234,   564, -2048,  2047,       0};
    tbl[1] = '{64'h07FF_0FFF_0001_0000,     0,     1,    -1,  110305};
    tbl[2] = '{64'h0800_8001_039A_F800, -2048,   922,     1, -155870};
    tbl[3] = '{64'hF7FF_0AAA_A555_7FFF,    -1,  1365, -1366,  110305};
    tbl[4] = '{64'h0000_0C00_0400_0080,   128,  1024, -1024,  -22750};

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Bytes offered while idle must be ignored
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      i_SPI_ByteValid = 1'($urandom_range(1, 0));
      i_SPI_Byte      = 8'($urandom);
    end
    i_SPI_ByteValid = 1'b0;

    // Table frames; a junk byte is offered during the request cycle
    for (int i = 0; i < 5; i++) begin
      wait_start(next_slot(cyc), "start_period");
      i_SPI_ByteValid = 1'b1;
      i_SPI_Byte      = 8'($urandom);
      @(negedge clk);
      i_SPI_ByteValid = 1'b0;
      exp_q.push_back({12'(tbl[i].x), 12'(tbl[i].y), 12'(tbl[i].z), 19'(tbl[i].t)});
      send_frame(tbl[i].frame, 8, 0, 0, (i == 0) ? 0 : 3);
      expect_frame("table");
    end

    // Randomized frames against the model
    for (int r = 0; r < 6; r++) begin
      wait_start(next_slot(cyc), "start_period");
      random_frame("random");
    end

    // Busy held for 10 cycles across a tick: start waits for busy to drop
    s = last_start;
    while (cyc < s + 58) @(negedge clk);
    i_SPI_Busy = 1'b1;
    ov0 = ov_cnt;
    repeat (10) @(negedge clk);
    i_SPI_Busy = 1'b0;
    wait_start(s + 69, "start_after_busy");
    check("busy_no_overrun", ov_cnt, ov0);
    random_frame("busy_frame");

    // Timeout after 5 bytes
    wait_start(next_slot(cyc), "start_period");
    to0 = to_cnt;
    dr0 = dr_cnt;
    f = {32'($urandom), 32'($urandom)};
    send_frame(f, 5, 1, 0, 2);
    for (int k = 0; k < 40 && to_cnt == to0; k++) @(negedge clk);
    check("timeout_cycle", to_cyc, last_byte_cyc + TO + 1);
    check("timeout_no_drdy", dr_cnt, dr0);
    check("timeout_hold", dut_word(), last_frame);
    wait_start(next_slot(cyc), "start_period");
    random_frame("after_timeout");

    // Overrun: frame stays in collection across the next tick
    wait_start(next_slot(cyc), "start_period");
    s = last_start;
    ov0 = ov_cnt;
    f = {32'($urandom), 32'($urandom)};
    exp_q.push_back(model(f));
    send_frame(f, 8, 1, 9, 9);
    expect_frame("overrun_frame");
    check("overrun_once", ov_cnt - ov0, 1);
    check("overrun_cycle", ov_cyc, s + P - 1);
    wait_start(last_byte_cyc + 3, "start_after_overrun");
    random_frame("pending_frame");

    // Reset in the middle of a frame
    wait_start(next_slot(cyc), "start_period");
    f = {32'($urandom), 32'($urandom)};
    send_frame(f, 3, 1, 0, 2);
    reset = 1'b1;
    #1;
    check_zero("midframe_reset");
    last_frame = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dr0 = dr_cnt;
    to0 = to_cnt;
    ov0 = ov_cnt;
    wait_start(P + 1, "start_after_reset");
    check("reset_quiet", {dr_cnt - dr0, to_cnt - to0, ov_cnt - ov0}, '0);
    random_frame("after_reset");

    // Global strobe properties
    repeat (3) @(negedge clk);
    check("single_cycle_strobes", dbl_cnt, 0);
    check("start_drdy_overlap", overlap_cnt, 0);
    check("overrun_total", ov_cnt, 1);
    check("timeout_total", to_cnt, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
